// File: rtl/shift_reg_ctrl_pkg.sv
// rtl/shift_reg_ctrl_pkg.sv - shared types and constants for the shift register controller
package shift_reg_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic MODE_HOLD  = 1'b0;
    localparam logic MODE_SHIFT = 1'b1;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - combinational two-way round-robin arbiter
module rr_arbiter2
    import shift_reg_ctrl_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = req_a | req_b;
        // On a tie the requester that did not win last time gets the grant.
        if (req_a && req_b) begin
            grant_id = ~last_grant;
        end else if (req_b) begin
            grant_id = OWN_B;
        end else begin
            grant_id = OWN_A;
        end
    end

endmodule

// File: rtl/shift_reg_controller.sv
// rtl/shift_reg_controller.sv - arbitrated load/hold/shift-out sequencer for a shared PIPO register
module shift_reg_controller
    import shift_reg_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    input  logic             mode_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    input  logic             mode_b,
    output logic             ack_a,
    output logic             ack_b,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic             busy,
    output logic             done,
    output logic             owner
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   reg_q, reg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ack_a_q, ack_a_d;
    logic               ack_b_q, ack_b_d;
    logic               done_q, done_d;
    logic               owner_q, owner_d;
    logic               last_grant_q, last_grant_d;

    logic               grant_valid;
    logic               grant_id;
    logic               gnt_mode;

    rr_arbiter2 u_arb (
        .req_a       (req_a),
        .req_b       (req_b),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        state_d      = state_q;
        reg_d        = reg_q;
        cnt_d        = cnt_q;
        ack_a_d      = 1'b0;
        ack_b_d      = 1'b0;
        done_d       = 1'b0;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        gnt_mode     = (grant_id == OWN_B) ? mode_b : mode_a;

        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    reg_d        = (grant_id == OWN_B) ? data_b : data_a;
                    owner_d      = grant_id;
                    last_grant_d = grant_id;
                    ack_a_d      = (grant_id == OWN_A);
                    ack_b_d      = (grant_id == OWN_B);
                    cnt_d        = '0;
                    // Hold transfers complete immediately, so done lines up with ack.
                    case (gnt_mode)
                        MODE_HOLD: begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                        MODE_SHIFT: state_d = SHIFT;
                        default:    state_d = SHIFT;
                    endcase
                end
            end
            SHIFT: begin
                reg_d = {reg_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            reg_q        <= '0;
            cnt_q        <= '0;
            ack_a_q      <= 1'b0;
            ack_b_q      <= 1'b0;
            done_q       <= 1'b0;
            owner_q      <= OWN_A;
            last_grant_q <= OWN_B;
        end else begin
            state_q      <= state_d;
            reg_q        <= reg_d;
            cnt_q        <= cnt_d;
            ack_a_q      <= ack_a_d;
            ack_b_q      <= ack_b_d;
            done_q       <= done_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign q          = reg_q;
    assign serial_out = (state_q == SHIFT) ? reg_q[WIDTH-1] : 1'b0;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign ack_a      = ack_a_q;
    assign ack_b      = ack_b_q;
    assign owner      = owner_q;

endmodule

// File: tb/tb_shift_reg_controller.sv
// tb/tb_shift_reg_controller.sv - directed table-driven bench for shift_reg_controller
module tb_shift_reg_controller;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       req_a, mode_a, req_b, mode_b;
    logic [3:0] data_a, data_b;
    logic       ack_a, ack_b, serial_out, busy, done, owner;
    logic [3:0] q;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic       ra;
        logic [3:0] da;
        logic       ma;
        logic       rb;
        logic [3:0] db;
        logic       mb;
        logic       exp_gnt;
        logic [3:0] exp_word;
        logic       exp_mode;
        logic [3:0] exp_final;
    } vec_t;

    vec_t vecs[6];

    shift_reg_controller #(.WIDTH(4), .CNT_W(3)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_a      (req_a),
        .data_a     (data_a),
        .mode_a     (mode_a),
        .req_b      (req_b),
        .data_b     (data_b),
        .mode_b     (mode_b),
        .ack_a      (ack_a),
        .ack_b      (ack_b),
        .q          (q),
        .serial_out (serial_out),
        .busy       (busy),
        .done       (done),
        .owner      (owner)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        bit got;
        req_a = v.ra; data_a = v.da; mode_a = v.ma;
        req_b = v.rb; data_b = v.db; mode_b = v.mb;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (ack_a || ack_b) got = 1;
        end
        chk("ack_seen", 32'(got), 1);
        req_a = 0; req_b = 0;
        if (!got) return;
        chk("ack_a", 32'(ack_a), 32'(!v.exp_gnt));
        chk("ack_b", 32'(ack_b), 32'(v.exp_gnt));
        chk("owner", 32'(owner), 32'(v.exp_gnt));
        chk("q_load", 32'(q), 32'(v.exp_word));
        if (!v.exp_mode) begin
            chk("done_with_ack", 32'(done), 1);
            @(negedge clock);
            chk("busy_after_hold", 32'(busy), 0);
            chk("done_one_cycle", 32'(done), 0);
            chk("q_held", 32'(q), 32'(v.exp_final));
        end else begin
            for (int k = 0; k < 4; k++) begin
                chk("serial_bit", 32'(serial_out), 32'(v.exp_word[3-k]));
                chk("done_early", 32'(done), 0);
                @(negedge clock);
            end
            chk("done_after_shift", 32'(done), 1);
            chk("q_shifted", 32'(q), 32'(v.exp_final));
            chk("serial_in_done", 32'(serial_out), 0);
            @(negedge clock);
            chk("busy_after_shift", 32'(busy), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_ack;

        //         ra da       ma rb db       mb gnt word     mode final
        vecs[0] = '{1, 4'b1011, 0, 0, 4'b0000, 0, 0, 4'b1011, 0, 4'b1011};
        vecs[1] = '{0, 4'b0000, 0, 1, 4'b1101, 1, 1, 4'b1101, 1, 4'b0000};
        vecs[2] = '{1, 4'b0110, 1, 0, 4'b0000, 0, 0, 4'b0110, 1, 4'b0000};
        vecs[3] = '{0, 4'b0000, 0, 1, 4'b0011, 0, 1, 4'b0011, 0, 4'b0011};
        vecs[4] = '{1, 4'b1001, 0, 1, 4'b0101, 0, 0, 4'b1001, 0, 4'b1001};
        vecs[5] = '{1, 4'b1001, 0, 1, 4'b0101, 0, 1, 4'b0101, 0, 4'b0101};

        reset_n = 0;
        req_a = 0; data_a = 0; mode_a = 0;
        req_b = 0; data_b = 0; mode_b = 0;
        repeat (2) @(negedge clock);
        chk("rst_q", 32'(q), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ack_a", 32'(ack_a), 0);
        chk("rst_ack_b", 32'(ack_b), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_serial", 32'(serial_out), 0);
        reset_n = 1;
        @(negedge clock);
        chk("idle_no_req_busy", 32'(busy), 0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Round-robin with both requesters held high from reset.
        reset_n = 0;
        @(negedge clock);
        reset_n = 1;
        req_a = 1; data_a = 4'b1100; mode_a = 0;
        req_b = 1; data_b = 4'b0011; mode_b = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            chk("rr_ack_a", 32'(ack_a), 32'(i % 4 == 0));
            chk("rr_ack_b", 32'(ack_b), 32'(i % 4 == 2));
            chk("rr_not_both", 32'(ack_a && ack_b), 0);
            if (i % 4 == 0) chk("rr_q_a", 32'(q), 32'(4'b1100));
            if (i % 4 == 2) chk("rr_q_b", 32'(q), 32'(4'b0011));
        end
        req_a = 0; req_b = 0;
        repeat (2) @(negedge clock);

        // Request from B while A is shifting.
        req_a = 1; data_a = 4'b1010; mode_a = 1;
        @(negedge clock);
        chk("busy_req_ack_a", 32'(ack_a), 1);
        req_a = 0;
        req_b = 1; data_b = 4'b0111; mode_b = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("no_ack_b_busy", 32'(ack_b), 0);
        end
        chk("busy_req_done_a", 32'(done), 1);
        @(negedge clock);
        chk("no_ack_b_first_idle", 32'(ack_b), 0);
        chk("idle_before_b", 32'(busy), 0);
        @(negedge clock);
        chk("late_ack_b", 32'(ack_b), 1);
        chk("late_q_b", 32'(q), 32'(4'b0111));
        chk("late_owner_b", 32'(owner), 1);
        req_b = 0;
        @(negedge clock);

        // Reset in the middle of a shift.
        req_a = 1; data_a = 4'b1111; mode_a = 1;
        @(negedge clock);
        chk("mid_ack_a", 32'(ack_a), 1);
        req_a = 0;
        repeat (2) @(negedge clock);
        chk("mid_busy_before", 32'(busy), 1);
        reset_n = 0;
        #1;
        chk("mid_rst_q", 32'(q), 0);
        chk("mid_rst_serial", 32'(serial_out), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_ack", 32'({ack_a, ack_b}), 0);
        chk("mid_rst_owner", 32'(owner), 0);
        repeat (2) @(negedge clock);
        reset_n = 1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            chk("mid_no_done", 32'(done), 0);
        end
        req_a = 1; data_a = 4'b0001; mode_a = 0;
        req_b = 1; data_b = 4'b0010; mode_b = 0;
        @(negedge clock);
        chk("post_rst_tie_a", 32'(ack_a), 1);
        chk("post_rst_tie_b", 32'(ack_b), 0);
        req_a = 0; req_b = 0;
        repeat (2) @(negedge clock);

        // Requester A keeps req high past its ack.
        n_ack = 0;
        req_a = 1; data_a = 4'b0101; mode_a = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (ack_a) n_ack++;
            if (k == 2) req_a = 0;
        end
        if (n_ack > 1) $display("protocol violation: requester A accepted %0d times", n_ack);
        chk("double_accept_count", 32'(n_ack), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_reg_controller.md
# shift_reg_controller

Sequencer and two-port arbiter for a shared WIDTH-bit parallel-in/parallel-out register.
- Two requesters (A, B) each submit a parallel word with a mode bit; the grant is round-robin.
- The block loads the word into its internal register.
- Mode 0: the word is held on the parallel output. Mode 1: the word is shifted out serially, MSB first.
- It sits between the lab's requester logic and the PIPO register datapath, replacing free-running clocked loads with sequenced, acknowledged transfers.

## Interface
- WIDTH, 4, register width in bits (≥2)
- CNT_W, 3, shift counter width; must satisfy 2^CNT_W > WIDTH

- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_a  in  1  requester A valid; held high with data_a/mode_a stable until ack_a seen
- data_a  in  WIDTH  A parallel word
- mode_a  in  1  0 = load-and-hold, 1 = load-and-shift-out
- req_b, data_b, mode_b  in  1/WIDTH/1  same as A for requester B
- ack_a, ack_b  out  1  one-cycle grant/accept pulse
- q  out  WIDTH  register contents, parallel output
- serial_out  out  1  q[WIDTH-1] while in SHIFT, else 0
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- owner  out  1  0 = A, 1 = B; holds the current or most recent grantee

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE, no request: the state holds and q holds.
- IDLE, any request at an edge:
  - Arbitrate and load q <= data of the grantee.
  - owner <= grantee, ack_grantee <= 1, last_grant <= grantee, cnt <= 0.
  - Next state: SHIFT if the grantee's mode = 1, else DONE.
- Arbitration:
  - Only one request high: grant it.
  - Both high: grant the requester that is not last_grant.
  - last_grant resets to B, so A wins the first tie.
- SHIFT, each edge:
  - q <= {q[WIDTH-2:0], 1'b0}; cnt <= cnt+1.
  - When cnt == WIDTH-1, go to DONE. This gives exactly WIDTH shift edges.
- DONE: done = 1 for one cycle; next state is IDLE.
- Final q: mode 0 holds the loaded word; mode 1 leaves q = 0.
- Requests raised while busy are not acknowledged. The requester keeps req high, and the request is arbitrated on the first IDLE edge.
- A req still high in IDLE after its ack is treated as a new request. Requesters must drop req on the edge following ack.
- ack_a and ack_b are never high together. ack and done are registered outputs.

## Timing
- Reset (asynchronous, any state): state = IDLE, q = 0, serial_out = 0, ack_a = ack_b = 0, done = 0, busy = 0, owner = 0, last_grant = B, cnt = 0.
- Reset during SHIFT aborts the transfer: no done is issued, and the in-flight word is lost.
- Grant edge E0: ack and q are valid in the cycle after E0.
- Mode 0: done is high in the cycle after E0, concurrent with ack; IDLE resumes at E1.
- Mode 1:
  - serial_out presents bit WIDTH-1 of the word in the cycle after E0, then the next lower bit each cycle, for WIDTH cycles.
  - done is high in cycle WIDTH+1 after E0; IDLE resumes at E(WIDTH+1).
- Back-to-back: the earliest next grant is the first edge at which the state is IDLE. Minimum throughput is one transfer per 2 cycles (mode 0) or WIDTH+2 cycles (mode 1).
- serial_out and busy are combinational from registered state and q; no input-to-output combinational path exists.

## Structure
- Shared package `shift_reg_ctrl_pkg`:
  - State enum {IDLE, SHIFT, DONE}.
  - Mode constants MODE_HOLD = 0, MODE_SHIFT = 1.
  - Owner constants OWN_A = 0, OWN_B = 1.
- Sub-module `rr_arbiter2`: combinational two-way round-robin.
  - Inputs: req_a, req_b, last_grant.
  - Outputs: grant_valid, grant_id.
- The last_grant register stays in the parent.
- The register, counter and FSM live in `shift_reg_controller`.

## Test plan
- Reset, then req_a = 1, data_a = 4'b1011, mode_a = 0 → ack_a and done high in the same cycle, q = 4'b1011 held, busy low after 2 cycles.
- req_b = 1, data_b = 4'b1101, mode_b = 1 → serial_out sequence 1,1,0,1 over 4 cycles, then done = 1, q = 0, owner = 1.
- req_a and req_b high together from reset, both mode 0 → order A, B, A, B across four transfers; ack_a and ack_b are never simultaneous.
- req_b asserted during A's SHIFT → no ack_b until A's done. ack_b arrives on the cycle after the first IDLE edge.
- reset_n pulsed low mid-SHIFT (after 2 shift edges) → all outputs return immediately to their reset values, no done, last_grant = B.
- Requester holds req_a high for a cycle after ack_a → a second transfer starts; checker flags the double-accept as a protocol violation.
